uarc_bus_responder: RTL
=======================

// Module: uarc_bus_responder
// PURPOSE
//  Target end of one UARC sender bus. core0 drives kill/incept/send/stream and the global_* payload.
//  This block answers with the matching *_ack pulses and queues sent/streamed words in a FIFO.
//  A local consumer (LED driver, UART, ...) drains the FIFO through a valid/ready port.
//  One instance sits on one bit of core0's sender_enables/*_acks vectors.
// PARAMETERS
//  WORD_MAG         5   log2 of word width; WORD_WIDTH = 1<<WORD_MAG
//  FIFO_ADDR_WIDTH  3   FIFO depth = 1<<FIFO_ADDR_WIDTH words
//  PERM_MASK        0   bits required in global_self_permission; 0 accepts all
// PORTS
//  clk                       in   1      clock, all logic on posedge
//  reset                     in   1      synchronous, active-high
//  sender_enable             in   1      this bus is selected by the core
//  global_kill               in   1      kill request
//  global_incept             in   1      incept request
//  global_send               in   1      single-word send request
//  global_stream             in   1      stream (burst) request, one word per cycle
//  global_data               in   WORD   payload word
//  global_self_permission    in   WORD   sender permission, checked against PERM_MASK
//  global_incept_permission  in   WORD   permission latched on incept
//  global_incept_address     in   WORD   address latched on incept
//  kill_ack                  out  1      1-cycle ack pulse
//  incept_ack                out  1      1-cycle ack pulse
//  send_ack                  out  1      1-cycle ack pulse
//  stream_ack                out  1      one pulse per accepted stream word
//  out_valid                 out  1      FIFO not empty
//  out_data                  out  WORD   FIFO head
//  out_ready                 in   1      consumer pops head when out_valid&out_ready
//  fifo_count                out  FAW+1  occupancy, 0..depth
//  incept_valid              out  1      incept registers hold a live value
//  incept_permission         out  WORD   latched permission
//  incept_address            out  WORD   latched address
//  perm_err                  out  1      sticky: a word was dropped for permission
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE. Reset mid-transfer drops the transfer; no ack is issued.
//  Request = global_X & sender_enable, sampled on posedge. Acks are registered, so latency is 1 cycle.
//  Priority in IDLE when several requests are seen: kill > incept > send > stream.
//  FSM states and transitions:
//   IDLE   kill -> ACK_K; incept -> ACK_I; send & !full -> ACK_S; stream -> STREAM.
//          send & full: stay IDLE, no ack; the sender keeps holding the request.
//   ACK_K  kill_ack=1; FIFO flushed, incept_valid=0, perm_err=0; next IDLE.
//   ACK_I  incept_ack=1; regs loaded from the IDLE-cycle sample, incept_valid=1 (overwrites); next IDLE.
//   ACK_S  send_ack=1; the word was written on the IDLE->ACK_S edge; requests ignored here; next IDLE.
//   STREAM each cycle with stream & !full, write global_data; stream_ack=1 the following cycle.
//          stream & full: no write, no ack (stall). !stream -> IDLE. kill -> ACK_K (aborts, flushes).
//          incept or send while in STREAM: ignored until the stream ends.
//  Permission rule: (global_self_permission & PERM_MASK) != PERM_MASK drops the word but still acks; perm_err<=1.
//  FIFO:
//   Write is gated by full as computed from the registered count. A pop in the same cycle does not free a slot.
//   Read and write in the same cycle, with 0<count<depth: count is unchanged.
//   Pointers wrap mod depth. count saturates at depth; it never wraps.
//   out_data is the head (registered or first-word-fall-through); it is valid only while out_valid.
//   Kill flush takes priority over a same-cycle pop or write.
// STRUCTURE
//  uarc_pkg: WORD_MAG-derived WORD_WIDTH localparam; typedef enum resp_state_t {IDLE,ACK_K,ACK_I,ACK_S,STREAM}.
//  Sub-module uarc_fifo #(WIDTH,ADDR_WIDTH): wr_en/wr_data, rd_en/rd_data, flush, count, full, empty.
//  Top of this block contains the FSM, permission check, incept registers and ack registers only.
// TESTING
//  1 reset held 3 cycles, mid-stream -> all outputs 0 and count=0 on the cycle after reset drops.
//  2 send 32'hDEADBEEF, enable=1 -> send_ack high exactly 1 cycle later; out_valid=1, out_data=DEADBEEF, count=1.
//  3 depth 8, out_ready=0, stream 10 words -> 8 stream_acks; stall with no ack on words 9-10.
//    Then out_ready=1 -> words 9-10 accepted; output order 1..10.
//  4 kill and send in the same cycle, count=5 -> kill_ack only; no send_ack; count=0, out_valid=0.
//  5 incept perm=32'h3, addr=32'h40 -> incept_ack 1 cycle later, incept_valid=1, regs 3/40.
//    Then kill -> incept_valid=0.
//  6 PERM_MASK=32'h1, send with self_permission=0 -> send_ack=1, count unchanged, perm_err=1.
//    perm_err stays 1 until the next kill.

Source files
------------

// File: rtl/uarc_pkg.sv
// Shared types and default sizing for the UARC bus responder slice.
package uarc_pkg;

    localparam int unsigned DEFAULT_WORD_MAG        = 5;
    localparam int unsigned DEFAULT_FIFO_ADDR_WIDTH = 3;

    function automatic int unsigned word_width(input int unsigned mag);
        return 32'd1 << mag;
    endfunction

    localparam int unsigned WORD_WIDTH = word_width(DEFAULT_WORD_MAG);

    typedef enum logic [2:0] {
        IDLE,
        ACK_K,
        ACK_I,
        ACK_S,
        STREAM
    } resp_state_t;

endpackage

// File: rtl/uarc_bus_responder_if.sv
// Sender-bus plus local consumer port of one UARC responder instance.
interface uarc_bus_responder_if
    import uarc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = uarc_pkg::WORD_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEFAULT_FIFO_ADDR_WIDTH + 1
);

    logic                   sender_enable;
    logic                   global_kill;
    logic                   global_incept;
    logic                   global_send;
    logic                   global_stream;
    logic [WORD_WIDTH-1:0]  global_data;
    logic [WORD_WIDTH-1:0]  global_self_permission;
    logic [WORD_WIDTH-1:0]  global_incept_permission;
    logic [WORD_WIDTH-1:0]  global_incept_address;

    logic                   kill_ack;
    logic                   incept_ack;
    logic                   send_ack;
    logic                   stream_ack;

    logic                   out_valid;
    logic [WORD_WIDTH-1:0]  out_data;
    logic                   out_ready;
    logic [COUNT_WIDTH-1:0] fifo_count;

    logic                   incept_valid;
    logic [WORD_WIDTH-1:0]  incept_permission;
    logic [WORD_WIDTH-1:0]  incept_address;
    logic                   perm_err;

    // Core plus consumer side.
    modport master (
        output sender_enable, global_kill, global_incept, global_send, global_stream,
               global_data, global_self_permission, global_incept_permission,
               global_incept_address, out_ready,
        input  kill_ack, incept_ack, send_ack, stream_ack, out_valid, out_data,
               fifo_count, incept_valid, incept_permission, incept_address, perm_err
    );

    // Responder side.
    modport slave (
        input  sender_enable, global_kill, global_incept, global_send, global_stream,
               global_data, global_self_permission, global_incept_permission,
               global_incept_address, out_ready,
        output kill_ack, incept_ack, send_ack, stream_ack, out_valid, out_data,
               fifo_count, incept_valid, incept_permission, incept_address, perm_err
    );

endinterface

// File: rtl/uarc_bus_responder_fifo.sv
// Word FIFO with first-word-fall-through head, saturating count and priority flush.
module uarc_fifo
    import uarc_pkg::*;
#(
    parameter int unsigned WIDTH      = uarc_pkg::WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ok;
    logic                  rd_ok;

    // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uarc_bus_responder.sv
// Target end of one UARC sender bus: request FSM, registered acks, incept registers,
// permission check, and a FIFO drained by a local valid/ready consumer.
module uarc_bus_responder
    import uarc_pkg::*;
#(
    parameter int unsigned                      WORD_MAG        = DEFAULT_WORD_MAG,
    parameter int unsigned                      FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH,
    parameter logic [word_width(WORD_MAG)-1:0]  PERM_MASK       = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    uarc_bus_responder_if.slave  bus
);

    localparam int unsigned WORD_W = word_width(WORD_MAG);

    resp_state_t       state_q, state_d;
    logic              kill_ack_q, kill_ack_d;
    logic              incept_ack_q, incept_ack_d;
    logic              send_ack_q, send_ack_d;
    logic              stream_ack_q, stream_ack_d;
    logic              incept_valid_q, incept_valid_d;
    logic [WORD_W-1:0] incept_perm_q, incept_perm_d;
    logic [WORD_W-1:0] incept_addr_q, incept_addr_d;
    logic              perm_err_q, perm_err_d;

    logic kill_req, incept_req, send_req, stream_req;
    logic perm_ok;
    logic take_word;
    logic fifo_wr_en, fifo_flush, fifo_full, fifo_empty;

    assign kill_req   = bus.global_kill   & bus.sender_enable;
    assign incept_req = bus.global_incept & bus.sender_enable;
    assign send_req   = bus.global_send   & bus.sender_enable;
    assign stream_req = bus.global_stream & bus.sender_enable;
    assign perm_ok    = ((bus.global_self_permission & PERM_MASK) == PERM_MASK);

    // Next-state, ack and FIFO control; a taken word is acked even when dropped for permission.
    always_comb begin
        state_d        = state_q;
        kill_ack_d     = 1'b0;
        incept_ack_d   = 1'b0;
        send_ack_d     = 1'b0;
        stream_ack_d   = 1'b0;
        incept_valid_d = incept_valid_q;
        incept_perm_d  = incept_perm_q;
        incept_addr_d  = incept_addr_q;
        perm_err_d     = perm_err_q;
        take_word      = 1'b0;
        fifo_wr_en     = 1'b0;
        fifo_flush     = 1'b0;

        case (state_q)
            IDLE: begin
                if (kill_req) begin
                    state_d = ACK_K;
                end else if (incept_req) begin
                    state_d        = ACK_I;
                    incept_ack_d   = 1'b1;
                    incept_valid_d = 1'b1;
                    incept_perm_d  = bus.global_incept_permission;
                    incept_addr_d  = bus.global_incept_address;
                end else if (send_req) begin
                    if (!fifo_full) begin
                        state_d    = ACK_S;
                        send_ack_d = 1'b1;
                        take_word  = 1'b1;
                    end
                end else if (stream_req) begin
                    state_d      = STREAM;
                    stream_ack_d = ~fifo_full;
                    take_word    = ~fifo_full;
                end
            end
            STREAM: begin
                if (kill_req) begin
                    state_d = ACK_K;
                end else if (!stream_req) begin
                    state_d = IDLE;
                end else if (!fifo_full) begin
                    stream_ack_d = 1'b1;
                    take_word    = 1'b1;
                end
            end
            ACK_K, ACK_I, ACK_S: state_d = IDLE;
            default:             state_d = IDLE;
        endcase

        if (state_d == ACK_K && state_q != ACK_K) begin
            kill_ack_d     = 1'b1;
            fifo_flush     = 1'b1;
            incept_valid_d = 1'b0;
            perm_err_d     = 1'b0;
        end

        if (take_word) begin
            fifo_wr_en = perm_ok;
            perm_err_d = perm_err_q | ~perm_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            kill_ack_q     <= 1'b0;
            incept_ack_q   <= 1'b0;
            send_ack_q     <= 1'b0;
            stream_ack_q   <= 1'b0;
            incept_valid_q <= 1'b0;
            incept_perm_q  <= '0;
            incept_addr_q  <= '0;
            perm_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_ack_q     <= kill_ack_d;
            incept_ack_q   <= incept_ack_d;
            send_ack_q     <= send_ack_d;
            stream_ack_q   <= stream_ack_d;
            incept_valid_q <= incept_valid_d;
            incept_perm_q  <= incept_perm_d;
            incept_addr_q  <= incept_addr_d;
            perm_err_q     <= perm_err_d;
        end
    end

    uarc_fifo #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr_en),
        .wr_data (bus.global_data),
        .rd_en   (bus.out_ready),
        .rd_data (bus.out_data),
        .count   (bus.fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.out_valid         = ~fifo_empty;
    assign bus.kill_ack          = kill_ack_q;
    assign bus.incept_ack        = incept_ack_q;
    assign bus.send_ack          = send_ack_q;
    assign bus.stream_ack        = stream_ack_q;
    assign bus.incept_valid      = incept_valid_q;
    assign bus.incept_permission = incept_perm_q;
    assign bus.incept_address    = incept_addr_q;
    assign bus.perm_err          = perm_err_q;

endmodule
